// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave backed by an internal word array, with programmable R/B latency.
// Read and write channels are independent FSMs, one outstanding transaction each.
module axi4_lite_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LATENCY = 2,
  parameter int                    WR_LATENCY = 2
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    pAXI4_ar_valid,
  output logic                    pAXI4_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   pAXI4_ar_bits_addr,
  output logic                    pAXI4_r_valid,
  input  logic                    pAXI4_r_ready,
  output logic [DATA_WIDTH-1:0]   pAXI4_r_bits_data,
  output logic [1:0]              pAXI4_r_bits_resp,
  input  logic                    pAXI4_aw_valid,
  output logic                    pAXI4_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   pAXI4_aw_bits_addr,
  input  logic                    pAXI4_w_valid,
  output logic                    pAXI4_w_ready,
  input  logic [DATA_WIDTH-1:0]   pAXI4_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] pAXI4_w_bits_strb,
  output logic                    pAXI4_b_valid,
  input  logic                    pAXI4_b_ready,
  output logic [1:0]              pAXI4_b_bits_resp
);

  localparam int MASK     = DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(MASK);
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0] SPAN = {{ADDR_WIDTH{1'b0}}, 1'b1} << (DEPTH_LOG2 + BYTE_LSB);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_WAIT, WR_RESP} wr_state_t;

  rd_state_t r_rd_state, w_rd_next;
  wr_state_t r_wr_state, w_wr_next;

  logic [ADDR_WIDTH-1:0] r_ar_addr, r_aw_addr;
  logic [3:0]            r_rd_cnt, r_wr_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [1:0]            r_rd_resp, r_b_resp;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic                  w_rd_ok, w_wr_ok;
  logic [DEPTH_LOG2-1:0] w_rd_idx, w_wr_idx;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < SPAN;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[BYTE_LSB +: DEPTH_LOG2];
  endfunction

  assign w_ar_hs  = pAXI4_ar_valid & pAXI4_ar_ready;
  assign w_r_hs   = pAXI4_r_valid  & pAXI4_r_ready;
  assign w_aw_hs  = pAXI4_aw_valid & pAXI4_aw_ready;
  assign w_w_hs   = pAXI4_w_valid  & pAXI4_w_ready;
  assign w_b_hs   = pAXI4_b_valid  & pAXI4_b_ready;
  assign w_rd_ok  = addr_ok(r_ar_addr);
  assign w_rd_idx = addr_idx(r_ar_addr);
  assign w_wr_ok  = addr_ok(r_aw_addr);
  assign w_wr_idx = addr_idx(r_aw_addr);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_rd_state <= RD_IDLE;
      r_ar_addr  <= '0;
      r_rd_cnt   <= '0;
      r_rd_data  <= '0;
      r_rd_resp  <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_ar_hs) begin
        r_ar_addr <= pAXI4_ar_bits_addr;
        r_rd_cnt  <= 4'(RD_LATENCY);
      end else if (r_rd_state == RD_WAIT) begin
        r_rd_cnt <= r_rd_cnt - 4'd1;
      end
      // Capture on entry to RD_RESP; a same-edge write is not yet visible, so the old word returns.
      if (r_rd_state != RD_RESP && w_rd_next == RD_RESP) begin
        r_rd_data <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_rd_resp <= w_rd_ok ? 2'b00 : 2'b11;
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_wr_state <= WR_IDLE;
      r_aw_addr  <= '0;
      r_wr_cnt   <= '0;
      r_b_resp   <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_aw_hs) r_aw_addr <= pAXI4_aw_bits_addr;
      if (w_w_hs) begin
        r_wr_cnt <= 4'(WR_LATENCY);
        r_b_resp <= w_wr_ok ? 2'b00 : 2'b11;
      end else if (r_wr_state == WR_WAIT) begin
        r_wr_cnt <= r_wr_cnt - 4'd1;
      end
    end
  end

  // NOTE: the array has no reset; its contents survive iReset and it maps onto plain RAM.
  always_ff @(posedge iClock) begin
    if (w_w_hs && w_wr_ok) begin
      for (int b = 0; b < MASK; b++) begin
        if (pAXI4_w_bits_strb[b]) r_mem[w_wr_idx][b*8 +: 8] <= pAXI4_w_bits_data[b*8 +: 8];
      end
    end
  end

  // NOTE: every combinational output is defaulted first so no latch is inferred.
  always_comb begin
    w_rd_next = r_rd_state;
    unique case (r_rd_state)
      RD_IDLE: if (w_ar_hs) w_rd_next = (RD_LATENCY == 0) ? RD_RESP : RD_WAIT;
      RD_WAIT: if (r_rd_cnt == 4'd1) w_rd_next = RD_RESP;
      RD_RESP: if (w_r_hs) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    w_wr_next = r_wr_state;
    unique case (r_wr_state)
      WR_IDLE: if (w_aw_hs) w_wr_next = WR_DATA;
      WR_DATA: if (w_w_hs) w_wr_next = (WR_LATENCY == 0) ? WR_RESP : WR_WAIT;
      WR_WAIT: if (r_wr_cnt == 4'd1) w_wr_next = WR_RESP;
      WR_RESP: if (w_b_hs) w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    pAXI4_ar_ready    = (r_rd_state == RD_IDLE) & ~iReset;
    pAXI4_r_valid     = (r_rd_state == RD_RESP) & ~iReset;
    pAXI4_r_bits_data = r_rd_data;
    pAXI4_r_bits_resp = r_rd_resp;
    pAXI4_aw_ready    = (r_wr_state == WR_IDLE) & ~iReset;
    pAXI4_w_ready     = (r_wr_state == WR_DATA) & ~iReset;
    pAXI4_b_valid     = (r_wr_state == WR_RESP) & ~iReset;
    pAXI4_b_bits_resp = r_b_resp;
  end

endmodule
